// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential restoring (shift-subtract) unsigned divider that
//               produces one quotient bit per clock. in_valid starts an
//               operation from IDLE, out_valid pulses for one cycle when the
//               registered quotient/remainder are updated. CONST_TIME=1 gives
//               a data-independent latency; CONST_TIME=0 takes an early exit
//               when either captured operand is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH_LOG  = 5,
    parameter int WIDTH      = 1 << WIDTH_LOG,
    parameter bit CONST_TIME = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             out_valid
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    // Iteration index of the final quotient bit; the counter tops out at
    // WIDTH on that step, which still fits in WIDTH_LOG+1 bits.
    localparam logic [WIDTH_LOG:0] c_last = (WIDTH_LOG + 1)'(WIDTH - 1);
    localparam logic [WIDTH_LOG:0] c_one  = (WIDTH_LOG + 1)'(1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_n;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_d;        // captured divisor
    logic [WIDTH:0]     r_r;        // partial remainder
    logic [WIDTH_LOG:0] r_count;
    logic               r_dbz;      // captured divisor was zero
    logic               r_zero_op;  // either captured operand was zero

    logic [WIDTH:0]     w_t;
    logic               w_ge;
    logic [WIDTH:0]     w_r_next;
    logic [WIDTH-1:0]   w_n_next;
    logic               w_early;
    logic               w_unused_rmsb;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. With a zero divisor the subtraction
    // always "fits", so the quotient becomes all ones and the remainder
    // collects the dividend bit by bit without any special casing.
    assign w_t      = {r_r[WIDTH-1:0], r_n[WIDTH-1]};
    assign w_ge     = (w_t >= {1'b0, r_d});
    assign w_r_next = w_ge ? (w_t - {1'b0, r_d}) : w_t;
    assign w_n_next = {r_n[WIDTH-2:0], w_ge};

    // The early exit only exists in the leaky variant.
    assign w_early = (CONST_TIME == 1'b0) && r_zero_op;

    // The top remainder bit only carries the intermediate t; it is never
    // shifted back in because r < d keeps it clear between iterations.
    assign w_unused_rmsb = r_r[WIDTH];

    assign busy = (r_state != c_idle);

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_n         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_count     <= '0;
            r_dbz       <= 1'b0;
            r_zero_op   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_n       <= dividend;
                        r_d       <= divisor;
                        r_r       <= '0;
                        r_count   <= '0;
                        r_dbz     <= (divisor == '0);
                        r_zero_op <= (dividend == '0) || (divisor == '0);
                        r_state   <= c_busy;
                    end
                end
                c_busy: begin
                    if (w_early) begin
                        // Skip the iterations and load the values the full
                        // algorithm would have produced for these operands.
                        if (r_dbz) begin
                            r_n       <= '1;
                            r_r       <= {1'b0, r_n};
                            quotient  <= '1;
                            remainder <= r_n;
                        end else begin
                            r_n       <= '0;
                            r_r       <= '0;
                            quotient  <= '0;
                            remainder <= '0;
                        end
                        div_by_zero <= r_dbz;
                        out_valid   <= 1'b1;
                        r_state     <= c_done;
                    end else begin
                        r_n     <= w_n_next;
                        r_r     <= w_r_next;
                        r_count <= r_count + c_one;
                        if (r_count == c_last) begin
                            quotient    <= w_n_next;
                            remainder   <= w_r_next[WIDTH-1:0];
                            div_by_zero <= r_dbz;
                            out_valid   <= 1'b1;
                            r_state     <= c_done;
                        end
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider. Instances a/b are the
//               constant-time pair, c/d the early-exit pair; a and c share
//               operands, b and d share the second operand set. Results of a
//               and c are checked against a reference model via queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] dividend_a, divisor_a, dividend_b, divisor_b;

    logic         busy_a, busy_b, busy_c, busy_d;
    logic [W-1:0] quotient_a, quotient_b, quotient_c, quotient_d;
    logic [W-1:0] remainder_a, remainder_b, remainder_c, remainder_d;
    logic         dbz_a, dbz_b, dbz_c, dbz_d;
    logic         ov_a, ov_b, ov_c, ov_d;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    bit   miter_on = 1'b0;
    exp_t sb_a[$];
    exp_t sb_c[$];
    exp_t ea;
    exp_t ec;

    always #5 clk = ~clk;

    // Cycle count, advanced on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider #(.WIDTH_LOG(5), .CONST_TIME(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .dividend(dividend_a), .divisor(divisor_a),
        .busy(busy_a), .quotient(quotient_a), .remainder(remainder_a),
        .div_by_zero(dbz_a), .out_valid(ov_a)
    );
    seq_divider #(.WIDTH_LOG(5), .CONST_TIME(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .dividend(dividend_b), .divisor(divisor_b),
        .busy(busy_b), .quotient(quotient_b), .remainder(remainder_b),
        .div_by_zero(dbz_b), .out_valid(ov_b)
    );
    seq_divider #(.WIDTH_LOG(5), .CONST_TIME(1'b0)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .dividend(dividend_a), .divisor(divisor_a),
        .busy(busy_c), .quotient(quotient_c), .remainder(remainder_c),
        .div_by_zero(dbz_c), .out_valid(ov_c)
    );
    seq_divider #(.WIDTH_LOG(5), .CONST_TIME(1'b0)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .dividend(dividend_b), .divisor(divisor_b),
        .busy(busy_d), .quotient(quotient_d), .remainder(remainder_d),
        .div_by_zero(dbz_d), .out_valid(ov_d)
    );

    // Reference model: plain division, all-ones/dividend on a zero divisor.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit ct, input int acc);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        e.lat = (!ct && (a == '0 || b == '0)) ? 1 : W;
        e.acc = acc;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return W'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard for instance a: every completion must match the oldest request.
    always @(negedge clk) begin
        if (rst === 1'b0 && ov_a === 1'b1) begin
            n_checks++;
            if (sb_a.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid_a cyc=%0d q=%h r=%h", cyc, quotient_a, remainder_a);
            end else begin
                ea = sb_a.pop_front();
                n_checks++;
                if ({quotient_a, remainder_a, dbz_a} !== {ea.q, ea.r, ea.dbz}) begin
                    n_fail++;
                    $display("FAIL result_a got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                             quotient_a, remainder_a, dbz_a, ea.q, ea.r, ea.dbz);
                end
                if ((cyc - ea.acc) !== ea.lat) begin
                    n_fail++;
                    $display("FAIL latency_a got %0d expected %0d", cyc - ea.acc, ea.lat);
                end
            end
        end
    end

    // Scoreboard for instance c (early-exit variant).
    always @(negedge clk) begin
        if (rst === 1'b0 && ov_c === 1'b1) begin
            n_checks++;
            if (sb_c.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid_c cyc=%0d q=%h r=%h", cyc, quotient_c, remainder_c);
            end else begin
                ec = sb_c.pop_front();
                n_checks++;
                if ({quotient_c, remainder_c, dbz_c} !== {ec.q, ec.r, ec.dbz}) begin
                    n_fail++;
                    $display("FAIL result_c got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                             quotient_c, remainder_c, dbz_c, ec.q, ec.r, ec.dbz);
                end
                if ((cyc - ec.acc) !== ec.lat) begin
                    n_fail++;
                    $display("FAIL latency_c got %0d expected %0d", cyc - ec.acc, ec.lat);
                end
            end
        end
    end

    // Constant-time pair must complete on exactly the same cycles.
    always @(negedge clk) begin
        if (miter_on && rst === 1'b0) begin
            n_checks++;
            if (ov_a !== ov_b) begin
                n_fail++;
                $display("FAIL miter_const_time cyc=%0d ov_a=%b ov_b=%b", cyc, ov_a, ov_b);
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] a2, input logic [W-1:0] b2);
        @(negedge clk);
        in_valid   = 1'b1;
        dividend_a = a;
        divisor_a  = b;
        dividend_b = a2;
        divisor_b  = b2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_acc = cyc;
        sb_a.push_back(model(a, b, 1'b1, cyc));
        sb_c.push_back(model(a, b, 1'b0, cyc));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb_a.size() != 0 || sb_c.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (sb_a.size() != 0 || sb_c.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending_a=%0d pending_c=%0d", sb_a.size(), sb_c.size());
            sb_a.delete();
            sb_c.delete();
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        dividend_a = '0;
        divisor_a  = '0;
        dividend_b = '0;
        divisor_b  = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_a, ov_a, dbz_a, quotient_a, remainder_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_state_a got busy=%b ov=%b dbz=%b q=%h r=%h expected all 0",
                     busy_a, ov_a, dbz_a, quotient_a, remainder_a);
        end
        n_checks++;
        if ({busy_c, ov_c, dbz_c, quotient_c, remainder_c} !== '0) begin
            n_fail++;
            $display("FAIL reset_state_c got busy=%b ov=%b dbz=%b q=%h r=%h expected all 0",
                     busy_c, ov_c, dbz_c, quotient_c, remainder_c);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        issue(32'd100, 32'd7, 32'd100, 32'd7);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_accept got %b expected 1", busy_a);
        end
        drain(40);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({quotient_a, remainder_a, busy_a, ov_a} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL result_hold got q=%0d r=%0d busy=%b ov=%b expected q=14 r=2 busy=0 ov=0",
                     quotient_a, remainder_a, busy_a, ov_a);
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] tab_a[8];
        logic [W-1:0] tab_b[8];
        tab_a = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'd0, 32'd0,
                  32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        tab_b = '{32'd0, 32'h10, 32'd5, 32'd0,
                  32'd9, 32'd1, 32'hFFFF_FFFF, 32'd3};
        for (int i = 0; i < 8; i++) begin
            issue(tab_a[i], tab_b[i], tab_a[i], tab_b[i]);
            drain(40);
        end
    endtask

    task automatic test_back_to_back();
        int acc1;
        issue(32'd50, 32'd5, 32'd50, 32'd5);
        acc1 = last_acc;
        repeat (5) @(negedge clk);
        // Requests while busy must be dropped, not queued.
        in_valid   = 1'b1;
        dividend_a = 32'd9;
        divisor_a  = 32'd3;
        dividend_b = 32'd9;
        divisor_b  = 32'd3;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        drain(40);
        issue(32'd9, 32'd3, 32'd9, 32'd3);
        n_checks++;
        if ((last_acc - acc1) !== (W + 2)) begin
            n_fail++;
            $display("FAIL accept_spacing got %0d expected %0d", last_acc - acc1, W + 2);
        end
        drain(40);
    endtask

    task automatic test_async_reset();
        issue(32'd1000, 32'd3, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy_a, ov_a, quotient_a, remainder_a} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_a got busy=%b ov=%b q=%h r=%h expected all 0",
                     busy_a, ov_a, quotient_a, remainder_a);
        end
        n_checks++;
        if ({busy_c, ov_c, quotient_c, remainder_c} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_c got busy=%b ov=%b q=%h r=%h expected all 0",
                     busy_c, ov_c, quotient_c, remainder_c);
        end
        sb_a.delete();
        sb_c.delete();
        @(negedge clk);
        rst = 1'b0;
        // Any out_valid in this window is flagged by the scoreboards.
        repeat (40) @(negedge clk);
        issue(32'd1000, 32'd3, 32'd1000, 32'd3);
        drain(40);
    endtask

    task automatic test_miter_const();
        logic [W-1:0] a, b, a2, b2;
        miter_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a  = rnd_op();
            b  = rnd_op();
            a2 = rnd_op();
            b2 = rnd_op();
            issue(a, b, a2, b2);
            drain(40);
        end
        repeat (3) @(negedge clk);
        miter_on = 1'b0;
    endtask

    task automatic test_miter_leaky();
        issue(32'd0, 32'd5, 32'd7, 32'd5);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ov_c !== 1'b1 || ov_d !== 1'b0) begin
            n_fail++;
            $display("FAIL miter_leaky cyc1 got ov_c=%b ov_d=%b expected ov_c=1 ov_d=0", ov_c, ov_d);
        end
        drain(40);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_async_reset();
        test_miter_const();
        test_miter_leaky();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench did not finish in time");
    end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
# seq_divider

Sequential restoring (shift-subtract) unsigned divider, one quotient bit per cycle, with the same in_valid/out_valid request–completion protocol as the team's shift-and-add multiplier. It is the inverse-operation partner of that unit. It is intended both as a datapath block and as a design-under-test for the two-copy timing-leakage miter harness. Parameter CONST_TIME selects between data-independent latency (leak-free) and a zero-operand early exit (deliberately leaky).

## Interface
Parameters:
- WIDTH_LOG, 5, log2 of operand width
- WIDTH, 1 << WIDTH_LOG, operand width
- CONST_TIME, 1, 1 = fixed latency for all operands; 0 = early exit on zero dividend or zero divisor

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned numerator, captured with request
- divisor  input  WIDTH  unsigned denominator, captured with request
- busy  output  1  high in BUSY and DONE
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  captured divisor was 0; qualified by out_valid
- out_valid  output  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: quotient 0, remainder 0, div_by_zero 0, out_valid 0, busy 0, counter 0.
- Reset clears everything immediately (asynchronous), including mid-operation. The in-flight request is dropped with no out_valid.
- IDLE with in_valid=1:
  - Capture n = dividend, d = divisor, r = 0 (WIDTH+1 bits), counter = 0.
  - Set div_by_zero_reg = (divisor == 0).
  - Go to BUSY.
- IDLE with in_valid=0: hold state.
- BUSY iteration, once per cycle:
  - t = {r[WIDTH-1:0], n[WIDTH-1]}
  - If t >= {1'b0,d}: r = t − d and qbit = 1; otherwise r = t and qbit = 0.
  - n = {n[WIDTH-2:0], qbit}. The quotient accumulates in n.
  - counter += 1.
- BUSY exit:
  - Iteration with counter == WIDTH−1 completes: go to DONE.
  - CONST_TIME=0 and captured operand zero: the first BUSY cycle does no iteration and goes directly to DONE, with n/r forced to the values below.
- Arithmetic and width rules:
  - r is WIDTH+1 bits so t never overflows.
  - r < d holds after every iteration whenever d ≠ 0.
  - Counter is WIDTH_LOG+1 bits and never wraps.
- On entering DONE: quotient ← n, remainder ← r[WIDTH-1:0], out_valid ← 1.
- Divide by zero, identical in both CONST_TIME modes: quotient = all ones, remainder = dividend, div_by_zero = 1. This falls out of the algorithm naturally, because t >= 0 is always true.
- Dividend 0 with divisor ≠ 0: quotient 0, remainder 0.
- DONE lasts exactly one cycle, then IDLE. out_valid drops to 0.
- quotient/remainder/div_by_zero hold until the next completion.
- in_valid asserted in BUSY or DONE is ignored: no capture, no state change, no queuing. The requester must re-assert in IDLE.

## Timing
- E0 = rising edge that samples in_valid=1 in IDLE.
- busy rises after E0.
- CONST_TIME=1:
  - Iterations occur at E1..E_WIDTH.
  - out_valid is high in the cycle after E_WIDTH (WIDTH cycles after E0) for all operands.
  - IDLE after E_WIDTH+1; earliest next accept at E_WIDTH+2.
  - Back-to-back initiation interval: WIDTH+2 cycles.
- CONST_TIME=0 with a zero operand:
  - DONE after E1; out_valid in the cycle after E1.
  - IDLE after E2; next accept at E3.
- Miter property with CONST_TIME=1: two instances receiving the same in_valid and arbitrary operands must have out_valid1 == out_valid2 on every cycle.
- Miter property with CONST_TIME=0: the same two-instance check must fail. A counterexample is one instance with dividend 0 and the other with dividend ≠ 0.

## Test plan
- WIDTH=32, CONST_TIME=1, dividend 100, divisor 7 at E0 -> out_valid exactly 32 cycles after E0, quotient 14, remainder 2, div_by_zero 0.
- Dividend 0xFFFFFFFF, divisor 0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFFF, div_by_zero 1. Latency is 32 with CONST_TIME=1 and 1 with CONST_TIME=0.
- Dividend 0xDEADBEEF, divisor 0x10 -> quotient 0x0DEADBEE, remainder 0xF.
- Request 50/5, then in_valid=1 with 9/3 during BUSY -> single out_valid, result 10 r 0. Re-issue 9/3 at the first IDLE edge -> 3 r 0, with accept-to-accept spacing of 34 cycles.
- Assert rst asynchronously 10 cycles after accepting 1000/3 -> outputs 0 and busy 0 immediately, no out_valid. Next request 1000/3 -> 333 r 1 after full latency.
- Two instances, CONST_TIME=1, random operand pairs for 1000 requests -> out_valid identical every cycle. Repeat with CONST_TIME=0 and pair (0/5, 7/5) -> out_valid mismatch at cycle 1 after E0.
